tdc_result_reader: RTL and testbench

SPI read sequencer that sits directly upstream of the measurement data-handling stage. When the TDC chip raises its interrupt, it fetches the 32-bit result register over SPI. It then presents the low 28 bits on `data_out` with a one-cycle `alu_triger` strobe, and re-arms the TDC with an init opcode. Each start and stop measurement produces exactly one strobe. The data-handling stage latches `data_out` on that strobe.

---
 rtl/tdc_result_reader_pkg.sv | 23 ++
 rtl/tdc_result_reader_spi_shift_engine.sv | 85 ++++++++
 rtl/tdc_result_reader.sv | 186 ++++++++++++++++++
 tb/tb_tdc_result_reader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_result_reader_pkg.sv
// Shared constants and state encoding for the TDC result reader.
// DATA_W is also used by the downstream data-handling stage.
package tdc_result_reader_pkg;

  localparam int DATA_W = 28;
  localparam int RX_W   = 32;
  localparam int NB_W   = 6;

  localparam logic [7:0] TDC_OP_RD_RES0 = 8'hB0;
  localparam logic [7:0] TDC_OP_INIT    = 8'h70;

  typedef enum logic [7:0] {
    ST_IDLE      = 8'b0000_0001,
    ST_CS_SETUP  = 8'b0000_0010,
    ST_SEND_RD   = 8'b0000_0100,
    ST_RECV      = 8'b0000_1000,
    ST_GAP1      = 8'b0001_0000,
    ST_INIT_CS   = 8'b0010_0000,
    ST_SEND_INIT = 8'b0100_0000,
    ST_GAP2      = 8'b1000_0000
  } state_e;

endpackage

// File: rtl/tdc_result_reader_spi_shift_engine.sv
// SPI mode-1 bit engine: SCK divider plus MSB-first tx/rx shift registers.
// done is high in the last clk cycle of the last bit so a new start can follow seamlessly.
module spi_shift_engine
  import tdc_result_reader_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [NB_W-1:0]   nbits,
  input  logic [7:0]        tx_byte,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic [RX_W-1:0]   rx_word,
  output logic              done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

  logic              active_q, active_d;
  logic              phase_q, phase_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [NB_W-1:0]   bit_q, bit_d;
  logic [7:0]        tx_q, tx_d;
  logic [RX_W-1:0]   rx_q, rx_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

  // phase_q = 0 is the SCK high half, which comes first in every bit
  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    div_d    = div_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    if (start) begin
      active_d = 1'b1;
      phase_d  = 1'b0;
      div_d    = DIV_LOAD;
      bit_d    = nbits - NB_W'(1);
      tx_d     = tx_byte;
    end else if (active_q) begin
      if (div_q != '0) begin
        div_d = div_q - DIV_W'(1);
      end else if (!phase_q) begin
        phase_d = 1'b1;
        div_d   = DIV_LOAD;
        rx_d    = {rx_q[RX_W-2:0], miso};
      end else if (bit_q == '0) begin
        active_d = 1'b0;
      end else begin
        phase_d = 1'b0;
        div_d   = DIV_LOAD;
        bit_d   = bit_q - NB_W'(1);
        tx_d    = {tx_q[6:0], 1'b0};
      end
    end
  end

  assign done    = active_q && phase_q && (div_q == '0) && (bit_q == '0);
  assign sck     = active_q && !phase_q;
  assign mosi    = active_q && tx_q[7];
  assign rx_word = rx_q;

endmodule

// File: rtl/tdc_result_reader.sv
// TDC result reader: on interrupt, reads result register 0 over SPI,
// strobes the low 28 bits downstream, then re-arms the TDC.
//
// state        | meaning
// IDLE         | waiting for irq with enable high
// CS_SETUP     | CS low, setup time before read opcode
// SEND_RD      | shifting out read opcode
// RECV         | shifting in 32-bit result
// GAP1         | CS high between frames, result strobed on entry
// INIT_CS      | CS low, setup time before init opcode
// SEND_INIT    | shifting out init opcode
// GAP2         | CS high before returning to idle
module tdc_result_reader
  import tdc_result_reader_pkg::*;
#(
  parameter int         CLK_DIV     = 4,
  parameter logic [7:0] RD_OPCODE   = TDC_OP_RD_RES0,
  parameter logic [7:0] INIT_OPCODE = TDC_OP_INIT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              tdc_intn,
  output logic              spi_ssn,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [DATA_W-1:0] data_out,
  output logic              alu_triger,
  output logic              busy,
  output logic              overrun
);

  localparam int TMR_W = $clog2(2 * CLK_DIV + 1);
  localparam logic [TMR_W-1:0] TMR_SETUP = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_GAP   = TMR_W'(2 * CLK_DIV - 1);
  // one extra cycle of CS setup ahead of the init frame
  localparam logic [TMR_W-1:0] TMR_INIT  = TMR_W'(CLK_DIV);

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [2:0]        sync_q, sync_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              alu_triger_q, alu_triger_d;
  logic              overrun_q, overrun_d;

  logic              eng_start;
  logic [NB_W-1:0]   eng_nbits;
  logic [7:0]        eng_tx;
  logic [RX_W-1:0]   eng_rx;
  logic              eng_done;
  logic [RX_W-DATA_W-1:0] rx_unused;

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (eng_start),
    .nbits   (eng_nbits),
    .tx_byte (eng_tx),
    .miso    (spi_miso),
    .sck     (spi_sck),
    .mosi    (spi_mosi),
    .rx_word (eng_rx),
    .done    (eng_done)
  );

  // top status nibble of the result register is not forwarded
  assign rx_unused = eng_rx[RX_W-1:DATA_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tmr_q        <= '0;
      sync_q       <= 3'b111;
      irq_q        <= 1'b0;
      data_out_q   <= '0;
      alu_triger_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      sync_q       <= sync_d;
      irq_q        <= irq_d;
      data_out_q   <= data_out_d;
      alu_triger_q <= alu_triger_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    eng_start = 1'b0;
    eng_nbits = NB_W'(8);
    eng_tx    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (irq_q && enable) begin
          state_d = ST_CS_SETUP;
          tmr_d   = TMR_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (tmr_q == '0) begin
          eng_start = 1'b1;
          eng_tx    = RD_OPCODE;
          state_d   = ST_SEND_RD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_SEND_RD: begin
        if (eng_done) begin
          eng_start = 1'b1;
          eng_nbits = NB_W'(RX_W);
          state_d   = ST_RECV;
        end
      end
      ST_RECV: begin
        if (eng_done) begin
          state_d = ST_GAP1;
          tmr_d   = TMR_GAP;
        end
      end
      ST_GAP1: begin
        if (tmr_q == '0) begin
          state_d = ST_INIT_CS;
          tmr_d   = TMR_INIT;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_INIT_CS: begin
        if (tmr_q == '0) begin
          eng_start = 1'b1;
          eng_tx    = INIT_OPCODE;
          state_d   = ST_SEND_INIT;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_SEND_INIT: begin
        if (eng_done) begin
          state_d = ST_GAP2;
          tmr_d   = TMR_GAP;
        end
      end
      ST_GAP2: begin
        if (tmr_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    spi_ssn = 1'b1;
    busy    = 1'b1;
    unique case (state_q)
      ST_IDLE:                         busy    = 1'b0;
      ST_CS_SETUP, ST_SEND_RD, ST_RECV,
      ST_INIT_CS, ST_SEND_INIT:        spi_ssn = 1'b0;
      default:                         spi_ssn = 1'b1;
    endcase
  end

  // sync_q[2] is the previous synchronized level, so irq marks a falling edge
  always_comb begin
    sync_d       = {sync_q[1:0], tdc_intn};
    irq_d        = sync_q[2] && !sync_q[1];
    alu_triger_d = (state_q == ST_RECV) && eng_done;
    data_out_d   = alu_triger_d ? eng_rx[DATA_W-1:0] : data_out_q;
    overrun_d    = irq_q && (state_q != ST_IDLE);
  end

  assign data_out   = data_out_q;
  assign alu_triger = alu_triger_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_tdc_result_reader.sv
// Directed bench for tdc_result_reader with a CPHA=1 TDC slave model on MISO.
module tb_tdc_result_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        tdc_intn = 1'b1;
  logic        spi_ssn;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  logic [27:0] data_out;
  logic        alu_triger;
  logic        busy;
  logic        overrun;

  tdc_result_reader #(
    .CLK_DIV     (4),
    .RD_OPCODE   (8'hB0),
    .INIT_OPCODE (8'h70)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .tdc_intn   (tdc_intn),
    .spi_ssn    (spi_ssn),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .data_out   (data_out),
    .alu_triger (alu_triger),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_irq = 0;
  int t_first = 0;

  int strobe_cnt = 0;
  int strobe_hi = 0;
  int strobe_cyc = 0;
  int overrun_cnt = 0;
  int busy_cnt = 0;
  logic trig_prev = 1'b0;

  logic [31:0] miso_word = 32'h0;
  int          sck_idx = 0;
  logic [7:0]  op_shift = 8'h0;
  int          frame_sck[$];
  logic [7:0]  frame_op[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (alu_triger) begin
      strobe_hi++;
      if (!trig_prev) begin
        strobe_cnt++;
        if (strobe_cnt == 1) strobe_cyc = cyc;
      end
    end
    trig_prev = alu_triger;
    if (overrun) overrun_cnt++;
    if (busy) busy_cnt++;
  end

  // TDC slave: drives result bits on SCK rising edges after the 8 opcode bits
  always @(negedge spi_ssn) begin
    sck_idx = 0;
    op_shift = 8'h0;
  end

  always @(posedge spi_sck) begin
    sck_idx++;
    if (sck_idx > 8 && sck_idx <= 40) spi_miso = miso_word[40 - sck_idx];
  end

  always @(negedge spi_sck) begin
    if (sck_idx >= 1 && sck_idx <= 8) op_shift = {op_shift[6:0], spi_mosi};
  end

  always @(posedge spi_ssn) begin
    frame_sck.push_back(sck_idx);
    frame_op.push_back(op_shift);
  end

  task automatic clear_stats();
    strobe_cnt = 0;
    strobe_hi = 0;
    strobe_cyc = 0;
    overrun_cnt = 0;
    busy_cnt = 0;
    frame_sck.delete();
    frame_op.delete();
  endtask

  task automatic fire_irq();
    @(posedge clk);
    #1;
    tdc_intn = 1'b0;
    t_irq = cyc;
    repeat (4) @(posedge clk);
    #1;
    tdc_intn = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'h0);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_read(input logic [31:0] word);
    clear_stats();
    miso_word = word;
    fire_irq();
    wait_idle();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    clear_stats();

    // idle after reset
    repeat (100) @(negedge clk);
    chk("rst_ssn", 32'(spi_ssn), 32'h1);
    chk("rst_sck", 32'(spi_sck), 32'h0);
    chk("rst_mosi", 32'(spi_mosi), 32'h0);
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_busy_cnt", 32'(busy_cnt), 32'h0);
    chk("rst_strobe_cnt", 32'(strobe_cnt), 32'h0);
    chk("rst_overrun_cnt", 32'(overrun_cnt), 32'h0);

    // normal read
    run_read(32'h0ABC_DEF1);
    chk("rd_data", 32'(data_out), 32'h0ABCDEF1);
    chk("rd_strobe_cnt", 32'(strobe_cnt), 32'h1);
    chk("rd_latency", 32'(strobe_cyc - t_irq), 32'd328);
    chk("rd_strobe_width", 32'(strobe_hi), 32'h1);
    chk("rd_busy_cycles", 32'(busy_cnt), 32'd409);
    chk("rd_frames", 32'(frame_sck.size()), 32'h2);
    if (frame_sck.size() == 2) begin
      chk("rd_f0_sck", 32'(frame_sck[0]), 32'd40);
      chk("rd_f0_op", 32'(frame_op[0]), 32'hB0);
      chk("rd_f1_sck", 32'(frame_sck[1]), 32'd8);
      chk("rd_f1_op", 32'(frame_op[1]), 32'h70);
    end
    chk("rd_overrun_cnt", 32'(overrun_cnt), 32'h0);

    // second interrupt 50 cycles into the first read
    clear_stats();
    miso_word = 32'h0123_4567;
    fire_irq();
    t_first = t_irq;
    repeat (45) @(posedge clk);
    fire_irq();
    chk("b2b_gap", 32'(t_irq - t_first), 32'd50);
    wait_idle();
    chk("b2b_overrun_cnt", 32'(overrun_cnt), 32'h1);
    chk("b2b_strobe_cnt", 32'(strobe_cnt), 32'h1);
    chk("b2b_data", 32'(data_out), 32'h01234567);
    chk("b2b_frames", 32'(frame_sck.size()), 32'h2);

    // interrupt ignored while disabled
    clear_stats();
    enable = 1'b0;
    miso_word = 32'hDEAD_BEEF;
    fire_irq();
    repeat (60) @(negedge clk);
    chk("dis_busy_cnt", 32'(busy_cnt), 32'h0);
    chk("dis_frames", 32'(frame_sck.size()), 32'h0);
    chk("dis_overrun_cnt", 32'(overrun_cnt), 32'h0);
    chk("dis_data", 32'(data_out), 32'h01234567);
    enable = 1'b1;
    run_read(32'hA555_5555);
    chk("en_data", 32'(data_out), 32'h05555555);
    chk("en_strobe_cnt", 32'(strobe_cnt), 32'h1);

    // reset at cycle 150 of a read
    clear_stats();
    miso_word = 32'h1111_2222;
    fire_irq();
    repeat (146) @(posedge clk);
    chk("mid_ssn_before", 32'(spi_ssn), 32'h0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_ssn", 32'(spi_ssn), 32'h1);
    chk("mid_sck", 32'(spi_sck), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_data", 32'(data_out), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    chk("mid_strobe_cnt", 32'(strobe_cnt), 32'h0);
    chk("mid_data_after", 32'(data_out), 32'h0);
    run_read(32'h1234_5678);
    chk("post_rst_data", 32'(data_out), 32'h02345678);
    chk("post_rst_strobe_cnt", 32'(strobe_cnt), 32'h1);

    // all-ones then all-zeros
    run_read(32'hFFFF_FFFF);
    chk("ones_data", 32'(data_out), 32'h0FFFFFFF);
    chk("ones_strobe_width", 32'(strobe_hi), 32'h1);
    run_read(32'h0000_0000);
    chk("zeros_data", 32'(data_out), 32'h0);
    chk("zeros_strobe_width", 32'(strobe_hi), 32'h1);
    chk("zeros_strobe_cnt", 32'(strobe_cnt), 32'h1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule
